// File: rtl/pixel_sensor_controller_pkg.sv
// Shared configuration for the pixel sensor array and the frame-sequencing controller.
// PixelSensorConfig holds array geometry; pixel_sensor_controller_pkg holds controller types.
package PixelSensorConfig;
  localparam int PIXEL_BITS         = 8;
  localparam int PIXEL_ARRAY_HEIGHT = 24;
endpackage

package pixel_sensor_controller_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ERASE_S,
    EXPOSE_S,
    CONVERT_S,
    READOUT_S
  } pixel_ctrl_state_t;

  localparam int DEFAULT_ERASE_CYCLES = 4;
endpackage

// File: rtl/pixel_sensor_controller_if.sv
// Row readout handshake between the controller and the downstream frame reader.
interface pixel_sensor_controller_if #(
  parameter int ROWS = PixelSensorConfig::PIXEL_ARRAY_HEIGHT
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROW_W-1:0] READ_ROW;
  logic             READ_VALID;
  logic             READ_READY;
  logic             FRAME_DONE;

  modport master (output READ_ROW, READ_VALID, FRAME_DONE, input READ_READY);
  modport slave  (input READ_ROW, READ_VALID, FRAME_DONE, output READ_READY);
endinterface

// File: rtl/pixel_sensor_controller_phase_timer.sv
// Loadable down-counter timing the ERASE and EXPOSE phases; done is high while the count is zero.
module phase_timer
  import pixel_sensor_controller_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/pixel_sensor_controller.sv
// Frame sequencer for the pixel sensor array: erase, expose, ramp ADC, then row readout.
// Define PIXEL_SENSOR_CONTROLLER_GRAY_EN to present CODE Gray-encoded.
module pixel_sensor_controller
  import pixel_sensor_controller_pkg::*;
#(
  parameter int ERASE_CYCLES = DEFAULT_ERASE_CYCLES,
  parameter int EXPOSE_BITS  = 8,
  parameter int ROWS         = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int CODE_BITS    = PixelSensorConfig::PIXEL_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [EXPOSE_BITS-1:0] EXPOSE_TIME,
  output logic                   ERASE,
  output logic                   EXPOSE,
  output logic                   RAMP,
  output logic                   CONVERT,
  output logic [CODE_BITS-1:0]   CODE,
  output logic                   BUSY,
  pixel_sensor_controller_if.master readout
);
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
  localparam int TIMER_W = (EXPOSE_BITS > ERASE_W) ? EXPOSE_BITS : ERASE_W;
  localparam logic [CODE_BITS-1:0] CODE_MAX   = '1;
  localparam logic [ROW_W-1:0]     LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [TIMER_W-1:0]   ERASE_LOAD = TIMER_W'(ERASE_CYCLES - 1);

  pixel_ctrl_state_t      state;
  logic [EXPOSE_BITS-1:0] expose_len;
  logic [CODE_BITS-1:0]   code_bin;
  logic [ROW_W-1:0]       read_row;
  logic                   read_valid;
  logic                   frame_done;
  logic                   timer_load;
  logic [TIMER_W-1:0]     timer_val;
  logic                   timer_done;

  // The timer is loaded on the edge that enters ERASE_S or EXPOSE_S, so it
  // reads zero exactly on the last cycle of each phase.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = ERASE_LOAD;
    if (state == IDLE && START && !frame_done) begin
      timer_load = 1'b1;
    end else if (state == ERASE_S && timer_done && !ABORT) begin
      timer_load = 1'b1;
      timer_val  = TIMER_W'(expose_len) - TIMER_W'(1);
    end
  end

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      CONVERT    <= 1'b0;
      BUSY       <= 1'b0;
      code_bin   <= '0;
      expose_len <= '0;
      read_row   <= '0;
      read_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != IDLE && ABORT) begin
        state      <= IDLE;
        ERASE      <= 1'b0;
        EXPOSE     <= 1'b0;
        RAMP       <= 1'b0;
        CONVERT    <= 1'b0;
        BUSY       <= 1'b0;
        code_bin   <= '0;
        read_row   <= '0;
        read_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A START landing on the FRAME_DONE cycle belongs to the old frame.
            if (START && !frame_done) begin
              state      <= ERASE_S;
              ERASE      <= 1'b1;
              BUSY       <= 1'b1;
              code_bin   <= '0;
              expose_len <= (EXPOSE_TIME == '0) ? EXPOSE_BITS'(1) : EXPOSE_TIME;
            end
          end
          ERASE_S: begin
            if (timer_done) begin
              state  <= EXPOSE_S;
              ERASE  <= 1'b0;
              EXPOSE <= 1'b1;
            end
          end
          EXPOSE_S: begin
            if (timer_done) begin
              state   <= CONVERT_S;
              EXPOSE  <= 1'b0;
              CONVERT <= 1'b1;
              RAMP    <= 1'b0;
            end
          end
          CONVERT_S: begin
            // Each step is RAMP low then high with a steady code; the code only
            // advances after the high half, and saturates on the final step.
            if (!RAMP) begin
              RAMP <= 1'b1;
            end else if (code_bin == CODE_MAX) begin
              state      <= READOUT_S;
              RAMP       <= 1'b0;
              CONVERT    <= 1'b0;
              read_valid <= 1'b1;
              read_row   <= '0;
            end else begin
              RAMP     <= 1'b0;
              code_bin <= code_bin + CODE_BITS'(1);
            end
          end
          READOUT_S: begin
            if (readout.READ_READY) begin
              if (read_row == LAST_ROW) begin
                state      <= IDLE;
                BUSY       <= 1'b0;
                read_valid <= 1'b0;
                read_row   <= '0;
                frame_done <= 1'b1;
              end else begin
                read_row <= read_row + ROW_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PIXEL_SENSOR_CONTROLLER_GRAY_EN
  function automatic logic [CODE_BITS-1:0] to_gray(input logic [CODE_BITS-1:0] b);
    return b ^ (b >> 1);
  endfunction
  assign CODE = to_gray(code_bin);
`else
  assign CODE = code_bin;
`endif

  assign readout.READ_ROW   = read_row;
  assign readout.READ_VALID = read_valid;
  assign readout.FRAME_DONE = frame_done;
endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Directed bench for pixel_sensor_controller with a frame-timeline model checked every cycle.
module tb_pixel_sensor_controller;
  localparam int E     = 4;
  localparam int ROWS  = 24;
  localparam int STEPS = 256;
`ifdef PIXEL_SENSOR_CONTROLLER_GRAY_EN
  localparam int EXP_LATCH = 55;
  localparam int EXP_FINAL = 128;
`else
  localparam int EXP_LATCH = 37;
  localparam int EXP_FINAL = 255;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] EXPOSE_TIME = 8'd0;
  logic       ERASE, EXPOSE, RAMP, CONVERT, BUSY;
  logic [7:0] CODE;

  pixel_sensor_controller_if #(.ROWS(ROWS)) rd ();

  pixel_sensor_controller #(
    .ERASE_CYCLES (E),
    .EXPOSE_BITS  (8),
    .ROWS         (ROWS),
    .CODE_BITS    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .START       (START),
    .ABORT       (ABORT),
    .EXPOSE_TIME (EXPOSE_TIME),
    .ERASE       (ERASE),
    .EXPOSE      (EXPOSE),
    .RAMP        (RAMP),
    .CONVERT     (CONVERT),
    .CODE        (CODE),
    .BUSY        (BUSY),
    .readout     (rd)
  );

  always #5 clk = ~clk;

  // Downstream reader: always ready, or ready on alternate cycles.
  int ready_mode = 0;
  always @(negedge clk) rd.READ_READY = (ready_mode == 0) ? 1'b1 : ~rd.READ_READY;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(input int b);
`ifdef PIXEL_SENSOR_CONTROLLER_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Frame model: position in the frame is a cycle offset m_k since START,
  // the readout phase tracks accepted rows.
  bit m_act = 0, m_rd = 0, m_fd = 0, m_fd_next = 0;
  int m_k = 0, m_x = 1, m_row = 0, m_code = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_rd = 0; m_fd = 0; m_k = 0; m_x = 1; m_row = 0; m_code = 0;
    end else begin
      m_fd_next = 0;
      if (!m_act) begin
        if (START && !m_fd) begin
          m_act = 1; m_k = 1; m_rd = 0; m_row = 0; m_code = 0;
          m_x = (EXPOSE_TIME == 8'd0) ? 1 : int'(EXPOSE_TIME);
        end
      end else if (ABORT) begin
        m_act = 0; m_rd = 0; m_row = 0; m_code = 0; m_k = 0;
      end else if (m_rd) begin
        if (rd.READ_READY) begin
          if (m_row == ROWS - 1) begin
            m_act = 0; m_rd = 0; m_row = 0; m_fd_next = 1;
          end else begin
            m_row++;
          end
        end
      end else begin
        m_k++;
        if (m_k > E + m_x + 2 * STEPS) begin
          m_rd = 1; m_row = 0; m_code = STEPS - 1;
        end
      end
      m_fd = m_fd_next;
    end
  end

  function automatic logic [19:0] model_out();
    logic er, ex, conv, ramp;
    int j, cb;
    er   = m_act && !m_rd && m_k >= 1 && m_k <= E;
    ex   = m_act && !m_rd && m_k > E && m_k <= E + m_x;
    j    = m_k - E - m_x - 1;
    conv = m_act && !m_rd && j >= 0 && j < 2 * STEPS;
    ramp = conv && (j % 2 == 1);
    cb   = conv ? j / 2 : m_code;
    return {m_act, er, ex, conv, ramp, m_rd, m_fd, 8'(enc(cb)), 5'(m_row)};
  endfunction

  function automatic logic [19:0] dut_out();
    return {BUSY, ERASE, EXPOSE, CONVERT, RAMP, rd.READ_VALID, rd.FRAME_DONE, CODE, rd.READ_ROW};
  endfunction

  // Observation counters and a sensor pixel holding value 37.
  int n_erase = 0, n_expose = 0, n_conv = 0, n_rise = 0, n_fd = 0, pulse_n = 0;
  logic prev_ramp = 1'b0, prev_conv = 1'b0;
  logic [7:0] latched = 8'd0, last_conv_code = 8'd0;
  always @(negedge clk) begin
    if (ERASE === 1'b1) n_erase++;
    if (EXPOSE === 1'b1) n_expose++;
    if (CONVERT === 1'b1) n_conv++;
    if (CONVERT === 1'b1 && prev_conv !== 1'b1) pulse_n = 0;
    if (RAMP === 1'b1 && prev_ramp !== 1'b1) begin
      n_rise++;
      pulse_n++;
      if (pulse_n == 38) latched = CODE;
    end
    if (CONVERT === 1'b1) last_conv_code = CODE;
    if (rd.FRAME_DONE === 1'b1) n_fd++;
    prev_ramp = RAMP;
    prev_conv = CONVERT;
  end

  int n_acc = 0;
  int acc_row [0:255];
  always @(posedge clk) begin
    if (!reset && rd.READ_VALID === 1'b1 && rd.READ_READY === 1'b1 && n_acc < 256) begin
      acc_row[n_acc] = int'(rd.READ_ROW);
      n_acc++;
    end
  end

  task automatic wait_fd(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd.FRAME_DONE === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic [7:0] t);
    EXPOSE_TIME = t;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask

  int s_erase, s_expose, s_conv, s_rise, s_fd, s_acc, bad;
  bit ok;

  initial begin
    fork
      forever begin
        @(negedge clk);
        check("cycle_outputs", 32'(dut_out()), 32'(model_out()));
      end
    join_none

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Frame 1: exposure 10, reader ready on alternate cycles, START retried while busy.
    ready_mode = 1;
    s_erase = n_erase; s_expose = n_expose; s_conv = n_conv; s_rise = n_rise;
    s_fd = n_fd; s_acc = n_acc;
    pulse_start(8'd10);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    wait_fd(2000, ok);
    check("frame1_done_seen", 32'(ok), 32'd1);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    check("start_at_done_ignored", 32'(BUSY), 32'd0);
    check("erase_cycles", 32'(n_erase - s_erase), 32'd4);
    check("expose_cycles", 32'(n_expose - s_expose), 32'd10);
    check("convert_cycles", 32'(n_conv - s_conv), 32'd512);
    check("ramp_rises", 32'(n_rise - s_rise), 32'd256);
    check("pixel37_latch", 32'(latched), 32'(EXP_LATCH));
    check("final_code", 32'(last_conv_code), 32'(EXP_FINAL));
    check("frame_done_pulses", 32'(n_fd - s_fd), 32'd1);
    check("rows_accepted", 32'(n_acc - s_acc), 32'd24);
    bad = 0;
    for (int i = 0; i < 24; i++) if (acc_row[s_acc + i] != i) bad++;
    check("row_order", 32'(bad), 32'd0);
    repeat (2) @(negedge clk);

    // Frame 2: exposure time 0 behaves as 1.
    ready_mode = 0;
    s_erase = n_erase; s_expose = n_expose; s_fd = n_fd;
    pulse_start(8'd0);
    wait_fd(2000, ok);
    check("frame2_done_seen", 32'(ok), 32'd1);
    check("expose_zero_cycles", 32'(n_expose - s_expose), 32'd1);
    check("frame2_erase_cycles", 32'(n_erase - s_erase), 32'd4);
    repeat (2) @(negedge clk);

    // Frame 3: abort in the middle of exposure.
    s_fd = n_fd;
    pulse_start(8'd20);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (EXPOSE === 1'b1) ok = 1;
    end
    check("expose_reached", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    check("abort_outputs", 32'(dut_out()), 32'd0);
    repeat (30) @(negedge clk);
    check("abort_no_frame_done", 32'(n_fd - s_fd), 32'd0);

    // Frame 4: asynchronous reset while converting at code 100.
    pulse_start(8'd5);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (CONVERT === 1'b1 && CODE == 8'(enc(100))) ok = 1;
    end
    check("code100_reached", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_convert", 32'(dut_out()), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'(BUSY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_sensor_controller.md
Name: pixel_sensor_controller

Overview:
- Frame-sequencing FSM directly upstream of the per-pixel analog sensor array; drives its ERASE, EXPOSE and RAMP inputs.
- Broadcasts the ADC code that the pixel memories latch when a pixel's CMP rises.
- Then sequences row readout to the downstream frame reader with a valid/ready handshake.
- One instance per sensor array; purely synchronous except for reset.

Parameters:
- ERASE_CYCLES, 4, clock cycles ERASE is held high (min 1).
- EXPOSE_BITS, 8, width of the exposure-time input.
- ROWS, PixelSensorConfig::PIXEL_ARRAY_HEIGHT, rows sequenced in readout.
- CODE_BITS, PixelSensorConfig::PIXEL_BITS, ADC code width; the ramp runs 2^CODE_BITS steps.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- START  in  1  begin frame; sampled in IDLE only.
- ABORT  in  1  cancel frame in progress.
- EXPOSE_TIME  in  EXPOSE_BITS  exposure length in cycles; latched on accepted START.
- ERASE  out  1  to sensor array.
- EXPOSE  out  1  to sensor array.
- RAMP  out  1  to sensor array; rising edge = one ADC step.
- CONVERT  out  1  high for the whole ramp phase; pixel memories track CMP only while high.
- CODE  out  CODE_BITS  ADC code presented to pixel memories.
- READ_ROW  out  $clog2(ROWS)  row being read.
- READ_VALID  out  1  READ_ROW valid for downstream.
- READ_READY  in  1  downstream accepts row.
- BUSY  out  1  high in any state except IDLE.
- FRAME_DONE  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- States: IDLE, ERASE_S, EXPOSE_S, CONVERT_S, READOUT_S.
- Reset (async): state IDLE; all outputs 0, including CODE=0 and READ_ROW=0.
- IDLE: START=1 -> ERASE_S next cycle. EXPOSE_TIME is latched; a value of 0 is treated as 1.
- ERASE_S: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE_S. CODE cleared to 0.
- EXPOSE_S: EXPOSE=1 for exactly the latched EXPOSE_TIME cycles, then CONVERT_S.
- CONVERT_S:
  - CONVERT=1. Each step n (n=1..2^CODE_BITS) is 2 cycles: RAMP=0 then RAMP=1, CODE=n-1 in both cycles.
  - The sensor's match on pulse n therefore sees CODE=n-1, which equals the pixel value.
  - CODE increments after each RAMP=1 cycle; no increment after the final step.
  - CODE holds 2^CODE_BITS-1 at exit and never wraps.
  - Phase length is exactly 2*2^CODE_BITS cycles; then READOUT_S with RAMP=0 and CONVERT=0.
- READOUT_S:
  - READ_VALID=1, READ_ROW starts at 0.
  - Advances only on READ_VALID & READ_READY.
  - READ_ROW and READ_VALID are stable while READ_READY=0.
  - Acceptance of row ROWS-1 -> FRAME_DONE=1 for one cycle, state IDLE, READ_VALID=0, READ_ROW=0.
- ABORT in any non-IDLE state -> IDLE next cycle; all outputs 0, no FRAME_DONE. ABORT has priority over every transition.
- START while BUSY is ignored. START coincident with FRAME_DONE is ignored; the next START accepted is the one seen in IDLE.
- ERASE, EXPOSE and CONVERT are mutually exclusive and glitch-free (registered outputs).
- Reset mid-frame: immediate return to reset values, same as the reset clause.

Optional Feature:
- Macro: PIXEL_SENSOR_CONTROLLER_GRAY_EN.
- Defined: CODE is output Gray-encoded (code ^ (code>>1)); the internal count stays binary and timing is unchanged.
- Undefined: CODE is plain binary.

Decomposition:
- PixelSensorConfig package supplies PIXEL_BITS and PIXEL_ARRAY_HEIGHT.
- Add to the package: a state enum typedef (pixel_ctrl_state_t) and the constant DEFAULT_ERASE_CYCLES.
- One sub-module, phase_timer: a loadable down-counter with a done flag, shared by the ERASE_S and EXPOSE_S durations.
- The Gray encoder stays an inline function inside the macro guard.

Test Plan:
- Reset mid-CONVERT (CODE=100) -> all outputs 0 asynchronously; IDLE; BUSY=0.
- START, EXPOSE_TIME=10, ERASE_CYCLES=4 -> ERASE high for 4 cycles, then EXPOSE high for 10, then 512 cycles of CONVERT (CODE_BITS=8).
- During CONVERT -> 256 RAMP rising edges; CODE equals k-1 on rising edge k; CODE=255 at exit. A sensor model with value 37 latches CODE=37.
- READOUT with ROWS=24 and READ_READY toggling every other cycle -> rows 0..23 accepted once each, in order, held while not ready. FRAME_DONE is a single pulse after row 23, then IDLE.
- ABORT during EXPOSE_S; START during BUSY; EXPOSE_TIME=0:
  - ABORT -> IDLE next cycle, no FRAME_DONE.
  - START while BUSY -> ignored.
  - EXPOSE_TIME=0 -> EXPOSE high for exactly 1 cycle.
- With PIXEL_SENSOR_CONTROLLER_GRAY_EN -> CODE sequence 0,1,3,2,6…; the final code is 128 (Gray of 255).
